// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - byte-stream image loader: packs big-endian words, writes memory, verifies XOR checksum, releases CPU reset
module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_ena_W,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_W,
  output logic        cpu_rst,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {CNT_HI, CNT_LO, DATA, WRITE, CSUM, DONE, ERR} state_t;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state, state_nxt;
  logic [15:0] count;
  logic [1:0]  idx;
  logic [31:0] word;
  logic [7:0]  acc;
  logic [31:0] addr;
  logic [15:0] wl;
  logic        take;
  logic [15:0] n_full;

  assign take   = in_valid && in_ready;
  assign n_full = {count[15:8], in_data};

  always_comb begin
    state_nxt = state;
    case (state)
      CNT_HI: if (take) state_nxt = CNT_LO;
      CNT_LO: if (take) begin
        if ({1'b0, n_full} > MAX_N) state_nxt = ERR;
        else if (n_full == 16'd0)   state_nxt = CSUM;
        else                        state_nxt = DATA;
      end
      DATA:   if (take && idx == 2'd3) state_nxt = WRITE;
      WRITE:  state_nxt = (wl + 16'd1 < count) ? DATA : CSUM;
      CSUM:   if (take) state_nxt = (in_data == acc) ? DONE : ERR;
      default: state_nxt = state;
    endcase
  end

  // Outputs are decoded from state or taken straight from registers.
  assign in_ready     = (state == CNT_HI) || (state == CNT_LO) || (state == DATA) || (state == CSUM);
  assign mem_ena_W    = (state == WRITE);
  assign mem_addr     = addr;
  assign mem_data_W   = word;
  assign cpu_rst      = (state != DONE);
  assign done         = (state == DONE);
  assign err          = (state == ERR);
  assign words_loaded = wl;

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= CNT_HI;
      count <= 16'd0;
      idx   <= 2'd0;
      word  <= 32'd0;
      acc   <= 8'd0;
      addr  <= BASE_ADDR;
      wl    <= 16'd0;
    end else begin
      state <= state_nxt;
      case (state)
        CNT_HI: if (take) count <= {in_data, 8'h00};
        CNT_LO: if (take) count[7:0] <= in_data;
        DATA: if (take) begin
          word <= {word[23:0], in_data};
          acc  <= acc ^ in_data;
          idx  <= idx + 2'd1;
        end
        // addr tracks BASE_ADDR + 4*words_loaded so it is already valid during WRITE.
        WRITE: begin
          wl   <= wl + 16'd1;
          addr <= addr + 32'd4;
        end
        default: ;
      endcase
    end
  end

endmodule
